alarm_trigger_ctrl: RTL and testbench

Downstream consumer of the alarm minute/hour counter. It compares the stored alarm time (BCD digits) with the running clock time (BCD digits) and starts ringing once when the two first match. It then runs ring-timeout, snooze and stop handling, and drives the buzzer and alarm LED outputs. It runs on the 1 Hz seconds clock, so one cycle is one second.

---
 rtl/alarm_trigger_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alarm_trigger_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger_ctrl.sv
// rtl/alarm_trigger_ctrl.sv - alarm match trigger with ring/snooze/lockout FSM; snooze limit under ALARM_SNOOZE_LIMIT_EN
module alarm_trigger_ctrl #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic       clk_out_seconds,
   input  logic       reset,
   input  logic       alarm_enable,
   input  logic [3:0] minutes_units,
   input  logic [2:0] minutes_tens,
   input  logic [3:0] hours_units,
   input  logic [1:0] hours_tens,
   input  logic [3:0] alarm_minutes_units,
   input  logic [2:0] alarm_minutes_tens,
   input  logic [3:0] alarm_hours_units,
   input  logic [1:0] alarm_hours_tens,
   input  logic       stop,
   input  logic       snooze,
   output logic       alarm_active,
   output logic       buzzer,
   output logic       alarm_led,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   localparam logic [8:0] RING_LOAD   = 9'(RING_SECS - 1);
   localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS - 1);

   state_t     state_q, state_d;
   logic [8:0] timer_q, timer_d;
   logic       match, match_q;
   // primed_q holds off triggering on the first edge after reset so a match
   // that is already held at release is sampled into match_q first
   logic       primed_q;
   logic       buzzer_q, buzzer_d;
   logic       alarm_active_q, alarm_active_d;
   logic       alarm_led_q, alarm_led_d;
   logic       trigger;

`ifdef ALARM_SNOOZE_LIMIT_EN
   localparam logic [7:0] SNOOZE_MAX = 8'(MAX_SNOOZE);
   logic [7:0] snooze_cnt_q, snooze_cnt_d;
`endif

   assign match = alarm_enable
                  && (minutes_units == alarm_minutes_units)
                  && (minutes_tens  == alarm_minutes_tens)
                  && (hours_units   == alarm_hours_units)
                  && (hours_tens    == alarm_hours_tens);

   assign trigger = match && !match_q && primed_q;

   // Next-state, timer and registered-output computation
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      buzzer_d = 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snooze_cnt_d = snooze_cnt_q;
`endif
      if (!alarm_enable) begin
         state_d = IDLE;
         timer_d = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
         snooze_cnt_d = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_d  = RINGING;
                  timer_d  = RING_LOAD;
                  buzzer_d = 1'b1;
`ifdef ALARM_SNOOZE_LIMIT_EN
                  snooze_cnt_d = '0;
`endif
               end
            end
            RINGING: begin
               if (stop) begin
                  state_d = LOCKOUT;
               end else if (snooze) begin
`ifdef ALARM_SNOOZE_LIMIT_EN
                  if (snooze_cnt_q >= SNOOZE_MAX) begin
                     state_d = LOCKOUT;
                  end else begin
                     state_d      = SNOOZE;
                     timer_d      = SNOOZE_LOAD;
                     snooze_cnt_d = snooze_cnt_q + 8'd1;
                  end
`else
                  state_d = SNOOZE;
                  timer_d = SNOOZE_LOAD;
`endif
               end else if (timer_q == '0) begin
                  state_d = LOCKOUT;
               end else begin
                  timer_d  = timer_q - 9'd1;
                  buzzer_d = ~buzzer_q;
               end
            end
            SNOOZE: begin
               if (stop) begin
                  state_d = LOCKOUT;
               end else if (timer_q == '0) begin
                  state_d  = RINGING;
                  timer_d  = RING_LOAD;
                  buzzer_d = 1'b1;
               end else begin
                  timer_d = timer_q - 9'd1;
               end
            end
            LOCKOUT: begin
               if (!match) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      alarm_active_d = (state_d == RINGING) || (state_d == SNOOZE);
      alarm_led_d    = (state_d == RINGING);
   end

   // State, timer, match history and output registers
   always_ff @(posedge clk_out_seconds or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         match_q        <= 1'b0;
         primed_q       <= 1'b0;
         buzzer_q       <= 1'b0;
         alarm_active_q <= 1'b0;
         alarm_led_q    <= 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
         snooze_cnt_q   <= '0;
`endif
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         match_q        <= match;
         primed_q       <= 1'b1;
         buzzer_q       <= buzzer_d;
         alarm_active_q <= alarm_active_d;
         alarm_led_q    <= alarm_led_d;
`ifdef ALARM_SNOOZE_LIMIT_EN
         snooze_cnt_q   <= snooze_cnt_d;
`endif
      end
   end

   assign alarm_active = alarm_active_q;
   assign buzzer       = buzzer_q;
   assign alarm_led    = alarm_led_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
// tb/tb_alarm_trigger_ctrl.sv - self-checking bench for alarm_trigger_ctrl
module tb_alarm_trigger_ctrl;

   localparam int RING_SECS   = 60;
   localparam int SNOOZE_SECS = 300;
   localparam int MAX_SNOOZE  = 3;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       stop;
   logic       snooze;
   logic [3:0] mu, hu, amu, ahu;
   logic [2:0] mt, amt;
   logic [1:0] ht, aht;
   logic       alarm_active, buzzer, alarm_led;
   logic [1:0] state_dbg;

   int cur_t;
   int alm_t;

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 idle, 1 ringing, 2 snoozing, 3 lockout
   int m_mode;
   int m_elapsed;
   int m_snoozes;
   bit m_prev;

   assign mu  = 4'(cur_t % 10);
   assign mt  = 3'((cur_t % 100) / 10);
   assign hu  = 4'((cur_t / 100) % 10);
   assign ht  = 2'(cur_t / 1000);
   assign amu = 4'(alm_t % 10);
   assign amt = 3'((alm_t % 100) / 10);
   assign ahu = 4'((alm_t / 100) % 10);
   assign aht = 2'(alm_t / 1000);

   alarm_trigger_ctrl #(
      .RING_SECS   (RING_SECS),
      .SNOOZE_SECS (SNOOZE_SECS),
      .MAX_SNOOZE  (MAX_SNOOZE)
   ) dut (
      .clk_out_seconds     (clk),
      .reset               (rst_n),
      .alarm_enable        (en),
      .minutes_units       (mu),
      .minutes_tens        (mt),
      .hours_units         (hu),
      .hours_tens          (ht),
      .alarm_minutes_units (amu),
      .alarm_minutes_tens  (amt),
      .alarm_hours_units   (ahu),
      .alarm_hours_tens    (aht),
      .stop                (stop),
      .snooze              (snooze),
      .alarm_active        (alarm_active),
      .buzzer              (buzzer),
      .alarm_led           (alarm_led),
      .state_dbg           (state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit cur_match();
      return en && (cur_t == alm_t);
   endfunction

   task automatic model_reset();
      m_mode    = 0;
      m_elapsed = 0;
      m_snoozes = 0;
      m_prev    = 1'b1;   // reset release behaves as if a match was already seen
   endtask

   task automatic model_edge();
      bit mt_now;
      mt_now = cur_match();
      if (!en) begin
         m_mode    = 0;
         m_snoozes = 0;
      end else begin
         case (m_mode)
            0: if (mt_now && !m_prev) begin
                  m_mode = 1; m_elapsed = 0; m_snoozes = 0;
               end
            1: if (stop) m_mode = 3;
               else if (snooze) begin
`ifdef ALARM_SNOOZE_LIMIT_EN
                  if (m_snoozes >= MAX_SNOOZE) m_mode = 3;
                  else begin m_mode = 2; m_elapsed = 0; m_snoozes++; end
`else
                  m_mode = 2; m_elapsed = 0; m_snoozes++;
`endif
               end else if (m_elapsed == RING_SECS - 1) m_mode = 3;
               else m_elapsed++;
            2: if (stop) m_mode = 3;
               else if (m_elapsed == SNOOZE_SECS - 1) begin m_mode = 1; m_elapsed = 0; end
               else m_elapsed++;
            default: if (!mt_now) m_mode = 0;
         endcase
      end
      m_prev = mt_now;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_state"},  32'(state_dbg),    32'(m_mode));
      chk({tag, "_active"}, 32'(alarm_active), 32'(m_mode == 1 || m_mode == 2));
      chk({tag, "_led"},    32'(alarm_led),    32'(m_mode == 1));
      chk({tag, "_buzzer"}, 32'(buzzer),       32'(m_mode == 1 && (m_elapsed % 2) == 0));
   endtask

   task automatic trigger_ring(input string tag);
      cur_t = 731; step();
      cur_t = 730; step();
      chk({tag, "_trigger"}, 32'(state_dbg), 32'd1);
   endtask

   task automatic wait_leave(input int st, output int n);
      n = 0;
      while (state_dbg == 2'(st) && n < 1000) begin
         n++;
         step();
      end
   endtask

   typedef struct {
      bit en;
      int t;
      bit stp;
      bit snz;
      int st;
      bit act;
      bit led;
      bit buz;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int n;
      tbl[0]  = '{1, 729, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 729, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 730, 0, 0, 1, 1, 1, 1};
      tbl[3]  = '{1, 730, 0, 0, 1, 1, 1, 0};
      tbl[4]  = '{1, 730, 0, 0, 1, 1, 1, 1};
      tbl[5]  = '{1, 730, 0, 0, 1, 1, 1, 0};
      tbl[6]  = '{1, 730, 1, 0, 3, 0, 0, 0};
      tbl[7]  = '{1, 730, 0, 0, 3, 0, 0, 0};
      tbl[8]  = '{1, 731, 0, 0, 0, 0, 0, 0};
      tbl[9]  = '{1, 730, 0, 0, 1, 1, 1, 1};
      tbl[10] = '{1, 730, 1, 1, 3, 0, 0, 0};
      tbl[11] = '{0, 730, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{1, 730, 0, 0, 1, 1, 1, 1};
      tbl[13] = '{0, 731, 0, 0, 0, 0, 0, 0};

      rst_n = 1'b0; en = 1'b0; stop = 1'b0; snooze = 1'b0;
      cur_t = 729; alm_t = 730;
      model_reset();
      step(); step();
      chk("reset_state",  32'(state_dbg),    32'd0);
      chk("reset_active", 32'(alarm_active), 32'd0);
      chk("reset_led",    32'(alarm_led),    32'd0);
      chk("reset_buzzer", 32'(buzzer),       32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         en = tbl[i].en; cur_t = tbl[i].t; stop = tbl[i].stp; snooze = tbl[i].snz;
         step();
         chk($sformatf("vec%0d_state", i),  32'(state_dbg),    32'(tbl[i].st));
         chk($sformatf("vec%0d_active", i), 32'(alarm_active), 32'(tbl[i].act));
         chk($sformatf("vec%0d_led", i),    32'(alarm_led),    32'(tbl[i].led));
         chk($sformatf("vec%0d_buzzer", i), 32'(buzzer),       32'(tbl[i].buz));
      end
      stop = 1'b0; snooze = 1'b0; en = 1'b1;

      // unattended ring times out after RING_SECS cycles
      trigger_ring("timeout");
      n = 0;
      while (state_dbg == 2'd1 && n < 100) begin
         chk("timeout_buzzer", 32'(buzzer), 32'((n % 2) == 0));
         n++;
         step();
      end
      chk("timeout_len",    n,                   RING_SECS);
      chk("timeout_state",  32'(state_dbg),      32'd3);
      chk("timeout_active", 32'(alarm_active),   32'd0);
      chk("timeout_buzz0",  32'(buzzer),         32'd0);

      // snooze at ring cycle 5; extra snooze pulses while snoozing are ignored
      trigger_ring("snz");
      repeat (4) step();
      snooze = 1'b1; step(); snooze = 1'b0;
      chk("snz_enter", 32'(state_dbg), 32'd2);
      n = 0;
      while (state_dbg == 2'd2 && n < 400) begin
         chk("snz_buzzer", 32'(buzzer),       32'd0);
         chk("snz_active", 32'(alarm_active), 32'd1);
         snooze = (n == 100 || n == 200);
         n++;
         step();
      end
      snooze = 1'b0;
      chk("snz_len",     n,               SNOOZE_SECS);
      chk("snz_resume",  32'(state_dbg),  32'd1);
      chk("snz_buzz1",   32'(buzzer),     32'd1);
      stop = 1'b1; step(); stop = 1'b0;
      chk("snz_stop", 32'(state_dbg), 32'd3);

      // snooze limit: fourth snooze of one event
      trigger_ring("lim");
      for (int k = 0; k < MAX_SNOOZE; k++) begin
         snooze = 1'b1; step(); snooze = 1'b0;
         chk("lim_snooze", 32'(state_dbg), 32'd2);
         wait_leave(2, n);
         chk("lim_back", 32'(state_dbg), 32'd1);
      end
      snooze = 1'b1; step(); snooze = 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
      chk("lim_fourth", 32'(state_dbg), 32'd3);
`else
      chk("lim_fourth", 32'(state_dbg), 32'd2);
`endif
      stop = 1'b1; step(); stop = 1'b0;
      chk("lim_stop", 32'(state_dbg), 32'd3);

      // asynchronous reset mid-ring, then held match must not retrigger
      trigger_ring("rst");
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_state",  32'(state_dbg),    32'd0);
      chk("rst_async_active", 32'(alarm_active), 32'd0);
      chk("rst_async_led",    32'(alarm_led),    32'd0);
      chk("rst_async_buzzer", 32'(buzzer),       32'd0);
      model_reset();
      step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("rst_held_idle", 32'(state_dbg), 32'd0);
      trigger_ring("rst_again");
      stop = 1'b1; step(); stop = 1'b0;
      check_model("post_directed");

      // randomized run against the reference model
      for (int i = 0; i < 4000; i++) begin
         en = ($urandom_range(0, 999) != 0);
         if ($urandom_range(0, 19) == 0)  cur_t = 729 + int'($urandom_range(0, 2));
         if ($urandom_range(0, 299) == 0) alm_t = 729 + int'($urandom_range(0, 2));
         stop   = ($urandom_range(0, 399) == 0);
         snooze = ($urandom_range(0, 29) == 0);
         step();
         check_model("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
